// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : state encoding and bus constants shared by the I2C target
// Rev 1.0
// ----------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ACK_A     = 4'd2,
      ST_PTR       = 4'd3,
      ST_WDATA     = 4'd4,
      ST_ACK_D     = 4'd5,
      ST_RDATA     = 4'd6,
      ST_RACK      = 4'd7,
      ST_WAIT_STOP = 4'd8
   } state_t;

   localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h50;
   localparam logic       ACK              = 1'b0;
   localparam logic       NACK             = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_bus_sync : SCL/SDA synchronizers with edge, START and STOP detection
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_hist_q;
   logic       sda_hist_q;
   logic       scl_s;

   // Everything resets to 1 so an idle bus produces no edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl};
         sda_sync_q <= {sda_sync_q[0], sda};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
      end
   end

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  =  scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s &  scl_hist_q;
   assign start_det =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
   assign stop_det  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_slave_mem : I2C target with pointer-addressed DEPTH x 8 register file
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_slave_mem
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR  = I2C_ADDR_DEFAULT,
   parameter int         DEPTH = 16,
   localparam int        AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl,
   inout  wire           sda,
   input  logic [AW-1:0] host_addr,
   output logic [7:0]    host_data,
   output logic          wr_strobe,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          busy
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      tx_q, tx_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            rw_q, rw_d;
   logic            done_q, done_d;
   logic            drive_low_q, drive_low_d;
   logic            busy_q, busy_d;
   logic            wr_strobe_q, wr_strobe_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            mem_we;
   logic [7:0]      rx_byte, rd_byte;
   logic [7:0]      mem_q [DEPTH];

   assign rx_byte = {shift_q[6:0], sda_s};
   assign rd_byte = mem_q[ptr_q];

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      done_d      = done_q;
      drive_low_d = drive_low_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mem_we      = 1'b0;
      if (stop_det) begin
         state_d     = ST_IDLE;
         drive_low_d = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
      end else if (start_det) begin
         state_d     = ST_ADDR;
         bit_cnt_d   = 3'd7;
         drive_low_d = 1'b0;
         done_d      = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               // done_q marks a complete byte waiting for the fall that opens its ACK slot
               if (scl_rise && !done_q) begin
                  shift_d = rx_byte;
                  if (bit_cnt_q == 3'd0) begin
                     done_d = 1'b1;
                     if (state_q == ST_PTR) ptr_d = rx_byte[AW-1:0];
                     if (state_q == ST_WDATA) begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = rx_byte;
                        ptr_d       = ptr_q + 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end else if (scl_fall && done_q) begin
                  done_d = 1'b0;
                  if (state_q != ST_ADDR) begin
                     state_d     = ST_ACK_D;
                     drive_low_d = 1'b1;
                  end else if (shift_q[7:1] == ADDR) begin
                     state_d     = ST_ACK_A;
                     drive_low_d = 1'b1;
                     busy_d      = 1'b1;
                     rw_d        = shift_q[0];
                  end else begin
                     state_d = ST_WAIT_STOP;
                     busy_d  = 1'b0;
                  end
               end
            end
            ST_ACK_A: if (scl_fall) begin
               bit_cnt_d = 3'd7;
               if (rw_q) begin
                  state_d     = ST_RDATA;
                  tx_d        = {rd_byte[6:0], 1'b0};
                  drive_low_d = ~rd_byte[7];
               end else begin
                  state_d     = ST_PTR;
                  drive_low_d = 1'b0;
               end
            end
            ST_ACK_D: if (scl_fall) begin
               state_d     = ST_WDATA;
               bit_cnt_d   = 3'd7;
               drive_low_d = 1'b0;
            end
            ST_RDATA: if (scl_fall) begin
               if (bit_cnt_q != 3'd0) begin
                  drive_low_d = ~tx_q[7];
                  tx_d        = {tx_q[6:0], 1'b0};
                  bit_cnt_d   = bit_cnt_q - 3'd1;
               end else begin
                  drive_low_d = 1'b0;
                  state_d     = ST_RACK;
                  done_d      = 1'b0;
               end
            end
            ST_RACK: begin
               // Pointer advances on the master's ACK; the next byte loads on the following fall.
               if (scl_rise && !done_q) begin
                  if (sda_s == ACK) begin
                     ptr_d  = ptr_q + 1'b1;
                     done_d = 1'b1;
                  end else begin
                     state_d = ST_WAIT_STOP;
                     busy_d  = 1'b0;
                  end
               end else if (scl_fall && done_q) begin
                  done_d      = 1'b0;
                  state_d     = ST_RDATA;
                  bit_cnt_d   = 3'd7;
                  tx_d        = {rd_byte[6:0], 1'b0};
                  drive_low_d = ~rd_byte[7];
               end
            end
            ST_IDLE, ST_WAIT_STOP: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd7;
         shift_q     <= 8'h00;
         tx_q        <= 8'h00;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         done_q      <= 1'b0;
         drive_low_q <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         done_q      <= done_d;
         drive_low_q <= drive_low_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         if (mem_we) mem_q[ptr_q] <= rx_byte;
      end
   end

   assign sda       = drive_low_q ? 1'b0 : 1'bz;
   assign host_data = mem_q[host_addr];
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/i2c_slave_mem.md
Name: i2c_slave_mem

Overview:
- Target-side I2C responder at 7-bit address ADDR, backed by a DEPTH x 8 register file. It sits on the far side of the bus from the team's I2C master and consumes that master's START, address, R/W, data and STOP sequence.
- SCL/SDA are oversampled on the system clock; no clock stretching.
- Transaction protocol: the first written byte sets the pointer; later bytes write memory with auto-increment. Reads stream from the pointer with auto-increment.
- A host-side read port and write strobe expose the register file to local logic.

Parameters:
- ADDR, 7'b1010000, bus address this target answers to.
- DEPTH, 16, register file entries (power of two); AW = log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- scl  input  1  I2C clock from master.
- sda  inout  1  open-drain data; driven 0 when drive_low, else high-Z.
- host_addr  input  AW  local read address.
- host_data  output  8  combinational mem[host_addr].
- wr_strobe  output  1  one-cycle pulse per bus-written data byte.
- wr_addr  output  AW  location written (valid with wr_strobe).
- wr_data  output  8  byte written (valid with wr_strobe).
- busy  output  1  high from address match until STOP/NACK-terminated transfer.

Behaviour:
- Input sampling:
  - scl and sda each pass through a 2-flop synchronizer, then a 1-flop history for edge detect.
  - Bus events act 3 clk after the pin change.
- Events:
  - START = sda fall while scl high. STOP = sda rise while scl high.
  - START is legal from any state, including a repeated START: go to ADDR, bit count 7, release SDA.
  - STOP from any state: go to IDLE, release SDA, busy=0.
- Shifting: receive bits are sampled on the scl rising edge, MSB first. Transmit bits are changed on the scl falling edge.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits. After the 8th rise, go to the ACK phase on the next scl fall:
    - upper 7 bits == ADDR: drive SDA low, busy=1.
    - mismatch: go to WAIT_STOP with SDA released.
  - ACK_A: hold SDA low for one scl high period; release on the following fall. Next state is PTR if R/W=0, or RDATA if R/W=1; RDATA drives mem[ptr] bit7 on that same fall.
  - PTR: receive 8 bits; ptr <= byte[AW-1:0] (upper bits ignored); ACK; then WDATA.
  - WDATA: receive 8 bits. On the 8th rise: mem[ptr] <= byte, wr_strobe pulses with wr_addr=ptr and wr_data=byte, ptr <= ptr+1. ACK, then back to WDATA.
  - RDATA: drive 8 bits of mem[ptr]. After the 8th bit's fall, release SDA and go to RACK.
  - RACK: sample SDA on the scl rise.
    - 0 (ACK): ptr+1, load the next byte, go to RDATA.
    - 1 (NACK): WAIT_STOP, busy=0.
  - WAIT_STOP: SDA released; ignore everything except START/STOP.
- Pointer wraps DEPTH-1 -> 0. All writes are ACKed; there is no overflow NACK.
- A STOP or START mid-byte discards the partial byte: no write, no strobe, ptr unchanged.
- Reset values:
  - SDA released; state IDLE; ptr 0; all mem entries 0x00.
  - wr_strobe 0, wr_addr 0, wr_data 0, busy 0.
  - Synchronizers reset to 1 (bus idle).
- Reset asserted mid-transfer releases SDA immediately (asynchronous).

Decomposition:
- Shared package i2c_pkg: state encoding enum, I2C_ADDR_DEFAULT = 7'h50, ACK = 1'b0, NACK = 1'b1.
- One sub-module, i2c_bus_sync: 2-flop synchronizers plus edge/START/STOP detection. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write: START, 0xA0, 0x03, 0xA5, 0x5A, STOP.
  -> ACK on all 4 bytes; mem[3]=0xA5, mem[4]=0x5A; two wr_strobe pulses (addr 3, then 4); host_addr=4 reads 0x5A; busy falls at STOP.
- Read with repeated START: write ptr 0x03, repeated START, 0xA1, master ACKs the first byte and NACKs the second.
  -> SDA carries 0xA5 then 0x5A; SDA released after the NACK; state WAIT_STOP until STOP.
- Wrong address: START, 0xA2 (addr 0x51).
  -> SDA never driven low through the ACK slot; no strobe; busy stays 0; subsequent bytes ignored until STOP.
- Wrap: ptr 0x0F, write 0x11, 0x22.
  -> mem[15]=0x11, mem[0]=0x22; wr_addr sequence 15, 0.
- Abort: STOP after 4 bits of a data byte.
  -> no write, ptr unchanged, IDLE. A new transaction to ptr 0x00 then succeeds.
- Reset mid-read: assert rst while driving a 0 bit.
  -> SDA high-Z within the same cycle; mem all 0x00; busy 0; next START responds normally.
